rvfpm_commit_sched: RTL and testbench
=====================================

Name: rvfpm_commit_sched

Overview:
In-order offload scheduler between the CORE-V-XIF issue/commit interfaces and the rvfpm execution model.
- Buffers instructions the predecoder has accepted, tagged by X_ID.
- Holds each one until the core commits or kills it.
- Releases committed instructions in program order to the FPU dispatch port. Killed instructions are discarded without reaching the FPU.

Parameters:
DEPTH, 4, number of in-flight offloaded instructions; power of two, ≥2
X_ID_WIDTH, 4, width of the XIF instruction ID
INSTR_WIDTH, 32, instruction word width

Ports:
ck  input  1  clock
rst  input  1  synchronous active-high reset
issue_valid  input  1  XIF issue request valid
issue_ready  output  1  scheduler can store an instruction
issue_accept  input  1  predecoder accepts the current issue_instr
issue_instr  input  INSTR_WIDTH  offloaded instruction
issue_id  input  X_ID_WIDTH  instruction ID
commit_valid  input  1  XIF commit strobe
commit_id  input  X_ID_WIDTH  ID being committed or killed
commit_kill  input  1  1 = kill, 0 = commit
dispatch_valid  output  1  head instruction is committed and ready for the FPU
dispatch_ready  input  1  FPU takes the instruction
dispatch_instr  output  INSTR_WIDTH  head instruction
dispatch_id  output  X_ID_WIDTH  head ID
occupancy  output  $clog2(DEPTH)+1  number of valid entries
err_commit  output  1  sticky: commit_id matched no pending entry
err_dup_id  output  1  sticky: issue_id already in flight at push

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All entries are invalidated; head/tail pointers and occupancy go to 0.
  - Sticky error flags clear.
  - While rst is high: issue_ready=0 and dispatch_valid=0.
  - Reset mid-operation drops all pending and committed entries silently.
- Storage:
  - Circular buffer of DEPTH entries, each holding {valid, committed, killed, id, instr}.
  - Pointers are $clog2(DEPTH)+1 bits wide; the MSB disambiguates full from empty.
  - Pointers wrap modulo DEPTH.
- issue_ready = !rst && occupancy<DEPTH, purely combinational.
  - Full-buffer issue_ready does not depend on a same-cycle pop.
- Push:
  - Condition: issue_valid && issue_ready && issue_accept at posedge.
  - The entry is written at tail with committed=0, killed=0.
  - If issue_valid && issue_ready && !issue_accept, nothing is stored.
- Duplicate ID:
  - A push whose issue_id matches a valid, non-killed entry sets err_dup_id.
  - The entry is still stored.
- Commit/kill:
  - On commit_valid, the oldest valid, non-killed, non-committed entry with a matching id gets committed=1 (kill=0) or killed=1 (kill=1).
  - No match sets err_commit and changes no state.
- Same-cycle commit and push of the same id:
  - If no older entry matches, the new entry is written with the commit/kill already applied.
- Dispatch:
  - dispatch_valid = head.valid && head.committed && !head.killed.
  - dispatch_instr/dispatch_id come combinationally from head and are 0 when the buffer is empty.
  - Head pops on dispatch_valid && dispatch_ready.
- Killed head:
  - A head entry with killed=1 is popped automatically, one per cycle, with dispatch_valid=0 that cycle.
- Latency:
  - A commit sampled at edge N makes an already-head entry visible as dispatch_valid in the cycle after N.
  - Issue+commit at the same edge gives dispatch_valid in the next cycle.
- Ordering:
  - Strictly in-order. A pending (uncommitted) head blocks younger committed entries.
- Simultaneous push and pop: occupancy is unchanged; both pointers advance.

Optional Feature:
RVFPM_SCHED_STATS_EN
- Defined: adds 32-bit saturating output counters stat_dispatched, stat_killed and stat_stall_cycles.
  - stat_stall_cycles counts cycles with dispatch_valid && !dispatch_ready.
  - All three counters clear on rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- pa_rvfpm gains:
  - typedef sched_entry_t {valid, committed, killed, id, instr};
  - the constant SCHED_DEPTH_DEFAULT.
- One natural sub-module is rvfpm_sched_id_match. It is combinational and returns the oldest-matching entry index plus a hit flag, given an id, the entry array and the head pointer.

Test Plan:
- Push id 3, commit id 3 at the next edge, dispatch_ready=1 → dispatch_valid=1 with dispatch_id=3 the following cycle; occupancy goes 1→0.
- Push ids 1,2,3,4 (DEPTH=4) with no commits → issue_ready=0 and occupancy=4. Commit+dispatch id 1 → issue_ready=1 the cycle after the pop.
- Push 5,6; commit 6, then kill 5 → 5 is popped silently with dispatch_valid=0, then 6 is dispatched next cycle. Only 6 reaches the FPU.
- commit_valid with id 9 and nothing in flight → err_commit=1 sticky, occupancy unchanged; rst clears it.
- Same-edge push id 7 and commit id 7 → dispatch_valid=1 in the next cycle; dispatch_ready=0 for 3 cycles keeps id 7 held stable.
- 3 entries pending, assert rst for one cycle → occupancy=0, dispatch_valid=0, and pushes are accepted normally afterwards.

Source files
------------

// File: rtl/rvfpm_commit_sched_pkg.sv
// Shared types and constants for the in-order XIF commit scheduler.
//   SCHED_DEPTH_DEFAULT       default number of in-flight entries
//   SCHED_ID_WIDTH_DEFAULT    default X_ID width
//   SCHED_INSTR_WIDTH_DEFAULT default instruction word width
//   sched_flags_t             per-entry status bits (width independent)
//   sched_entry_t             full entry at the default widths
//   sched_ptr_bits()          pointer width: index bits plus one wrap bit
package rvfpm_commit_sched_pkg;

    localparam int SCHED_DEPTH_DEFAULT       = 4;
    localparam int SCHED_ID_WIDTH_DEFAULT    = 4;
    localparam int SCHED_INSTR_WIDTH_DEFAULT = 32;

    typedef struct packed {
        logic valid;
        logic committed;
        logic killed;
    } sched_flags_t;

    typedef struct packed {
        logic                                 valid;
        logic                                 committed;
        logic                                 killed;
        logic [SCHED_ID_WIDTH_DEFAULT-1:0]    id;
        logic [SCHED_INSTR_WIDTH_DEFAULT-1:0] instr;
    } sched_entry_t;

    function automatic int sched_ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rvfpm_commit_sched_if.sv
// Issue / commit / dispatch bundle between the core-side XIF adapter
// (master) and the commit scheduler (slave).
//   issue_*    : offload request with predecoder accept
//   commit_*   : commit / kill strobe for an in-flight X_ID
//   dispatch_* : committed head instruction handed to the FPU
interface rvfpm_commit_sched_if #(
    parameter int X_ID_WIDTH  = 4,
    parameter int INSTR_WIDTH = 32
);
    logic                   issue_valid;
    logic                   issue_ready;
    logic                   issue_accept;
    logic [INSTR_WIDTH-1:0] issue_instr;
    logic [X_ID_WIDTH-1:0]  issue_id;
    logic                   commit_valid;
    logic [X_ID_WIDTH-1:0]  commit_id;
    logic                   commit_kill;
    logic                   dispatch_valid;
    logic                   dispatch_ready;
    logic [INSTR_WIDTH-1:0] dispatch_instr;
    logic [X_ID_WIDTH-1:0]  dispatch_id;

    modport master (
        output issue_valid, issue_accept, issue_instr, issue_id,
        output commit_valid, commit_id, commit_kill,
        output dispatch_ready,
        input  issue_ready, dispatch_valid, dispatch_instr, dispatch_id
    );

    modport slave (
        input  issue_valid, issue_accept, issue_instr, issue_id,
        input  commit_valid, commit_id, commit_kill,
        input  dispatch_ready,
        output issue_ready, dispatch_valid, dispatch_instr, dispatch_id
    );
endinterface

// File: rtl/rvfpm_commit_sched_id_match.sv
// rvfpm_sched_id_match: combinational search for the oldest entry that is
// still waiting for a commit/kill decision and carries the given id.
//   id        : X_ID to look for
//   flags     : per-entry status bits
//   ids       : per-entry X_ID
//   head_idx  : index of the oldest entry; search proceeds from here
//   hit       : some waiting entry matched
//   hit_idx   : index of the oldest matching entry (0 when no hit)
module rvfpm_sched_id_match
    import rvfpm_commit_sched_pkg::*;
#(
    parameter int DEPTH      = SCHED_DEPTH_DEFAULT,
    parameter int X_ID_WIDTH = SCHED_ID_WIDTH_DEFAULT,
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic [X_ID_WIDTH-1:0] id,
    input  sched_flags_t          flags [DEPTH],
    input  logic [X_ID_WIDTH-1:0] ids   [DEPTH],
    input  logic [IW-1:0]         head_idx,
    output logic                  hit,
    output logic [IW-1:0]         hit_idx
);

    logic [DEPTH-1:0] match_vec;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_vec[gi] = flags[gi].valid && !flags[gi].killed &&
                                   !flags[gi].committed && (ids[gi] == id);
        end
    endgenerate

    // Walk from the head so the first hit is the oldest; DEPTH is a power
    // of two, so the index add wraps on its own.
    always_comb begin
        logic [IW-1:0] pos;
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head_idx + IW'(k);
            if (!hit && match_vec[pos]) begin
                hit     = 1'b1;
                hit_idx = pos;
            end
        end
    end

endmodule

// File: rtl/rvfpm_commit_sched.sv
// rvfpm_commit_sched: in-order offload scheduler between the XIF
// issue/commit interfaces and the rvfpm execution model. Accepted
// instructions wait in a circular buffer until committed or killed;
// committed ones leave in program order on the dispatch port, killed ones
// are dropped at the head one per cycle.
//   ck, rst     : clock, synchronous active-high reset
//   xif         : issue / commit / dispatch bundle (slave side)
//   occupancy   : number of valid entries
//   err_commit  : sticky, a commit/kill id matched no waiting entry
//   err_dup_id  : sticky, a pushed id was already in flight
// Optional build macro RVFPM_SCHED_STATS_EN adds saturating 32-bit
// counters stat_dispatched, stat_killed and stat_stall_cycles.
module rvfpm_commit_sched
    import rvfpm_commit_sched_pkg::*;
#(
    parameter int DEPTH       = SCHED_DEPTH_DEFAULT,
    parameter int X_ID_WIDTH  = SCHED_ID_WIDTH_DEFAULT,
    parameter int INSTR_WIDTH = SCHED_INSTR_WIDTH_DEFAULT,
    localparam int PW         = sched_ptr_bits(DEPTH),
    localparam int IW         = $clog2(DEPTH)
) (
    input  logic                 ck,
    input  logic                 rst,
    rvfpm_commit_sched_if.slave  xif,
    output logic [PW-1:0]        occupancy,
    output logic                 err_commit,
    output logic                 err_dup_id
`ifdef RVFPM_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_dispatched,
    output logic [31:0]          stat_killed,
    output logic [31:0]          stat_stall_cycles
`endif
);

    sched_flags_t           flags_reg [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_reg    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_reg [DEPTH];
    logic [PW-1:0]          head_reg, tail_reg;
    logic                   err_commit_reg, err_dup_id_reg;

    logic [IW-1:0] head_idx, tail_idx, cm_idx;
    logic          cm_hit, push, push_cm, pop, head_killed_pop, dispatch_fire;
    logic [DEPTH-1:0] dup_vec;
    sched_flags_t  head_flags;

    assign head_idx   = head_reg[IW-1:0];
    assign tail_idx   = tail_reg[IW-1:0];
    assign head_flags = flags_reg[head_idx];
    assign occupancy  = tail_reg - head_reg;

    assign xif.issue_ready    = !rst && (occupancy < PW'(DEPTH));
    assign xif.dispatch_valid = !rst && head_flags.valid && head_flags.committed &&
                                !head_flags.killed;
    assign xif.dispatch_instr = head_flags.valid ? instr_reg[head_idx] : '0;
    assign xif.dispatch_id    = head_flags.valid ? id_reg[head_idx] : '0;

    assign push            = xif.issue_valid && xif.issue_ready && xif.issue_accept;
    assign dispatch_fire   = xif.dispatch_valid && xif.dispatch_ready;
    assign head_killed_pop = head_flags.valid && head_flags.killed;
    assign pop             = dispatch_fire || head_killed_pop;

    rvfpm_sched_id_match #(
        .DEPTH      (DEPTH),
        .X_ID_WIDTH (X_ID_WIDTH)
    ) u_id_match (
        .id       (xif.commit_id),
        .flags    (flags_reg),
        .ids      (id_reg),
        .head_idx (head_idx),
        .hit      (cm_hit),
        .hit_idx  (cm_idx)
    );

    // A commit that finds no older waiting entry may target the instruction
    // being pushed in the same cycle.
    assign push_cm = push && xif.commit_valid && !cm_hit &&
                     (xif.issue_id == xif.commit_id);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign dup_vec[gi] = flags_reg[gi].valid && !flags_reg[gi].killed &&
                                 (id_reg[gi] == xif.issue_id);

            // Push only targets a free slot and commit/pop only target
            // occupied ones, so the three updates never collide on a slot.
            always_ff @(posedge ck) begin
                if (rst) begin
                    flags_reg[gi] <= '0;
                end else if (push && (tail_idx == IW'(gi))) begin
                    flags_reg[gi].valid     <= 1'b1;
                    flags_reg[gi].committed <= push_cm && !xif.commit_kill;
                    flags_reg[gi].killed    <= push_cm && xif.commit_kill;
                end else begin
                    if (xif.commit_valid && cm_hit && (cm_idx == IW'(gi))) begin
                        flags_reg[gi].committed <= !xif.commit_kill;
                        flags_reg[gi].killed    <= xif.commit_kill;
                    end
                    if (pop && (head_idx == IW'(gi))) begin
                        flags_reg[gi].valid <= 1'b0;
                    end
                end
            end

            // Payload needs no reset: it is only observed behind valid.
            always_ff @(posedge ck) begin
                if (push && (tail_idx == IW'(gi))) begin
                    id_reg[gi]    <= xif.issue_id;
                    instr_reg[gi] <= xif.issue_instr;
                end
            end
        end
    endgenerate

    always_ff @(posedge ck) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            err_commit_reg <= 1'b0;
            err_dup_id_reg <= 1'b0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            if (xif.commit_valid && !cm_hit && !push_cm) err_commit_reg <= 1'b1;
            if (push && (|dup_vec)) err_dup_id_reg <= 1'b1;
        end
    end

    assign err_commit = err_commit_reg;
    assign err_dup_id = err_dup_id_reg;

`ifdef RVFPM_SCHED_STATS_EN
    logic [31:0] stat_dispatched_reg, stat_killed_reg, stat_stall_reg;

    always_ff @(posedge ck) begin
        if (rst) begin
            stat_dispatched_reg <= '0;
            stat_killed_reg     <= '0;
            stat_stall_reg      <= '0;
        end else begin
            if (dispatch_fire && (stat_dispatched_reg != '1))
                stat_dispatched_reg <= stat_dispatched_reg + 1'b1;
            if (head_killed_pop && (stat_killed_reg != '1))
                stat_killed_reg <= stat_killed_reg + 1'b1;
            if (xif.dispatch_valid && !xif.dispatch_ready && (stat_stall_reg != '1))
                stat_stall_reg <= stat_stall_reg + 1'b1;
        end
    end

    assign stat_dispatched   = stat_dispatched_reg;
    assign stat_killed       = stat_killed_reg;
    assign stat_stall_cycles = stat_stall_reg;
`endif

endmodule

// File: tb/tb_rvfpm_commit_sched.sv
// Directed bench for rvfpm_commit_sched (DEPTH=4). Inputs change 1 ns after
// each rising edge; outputs are checked at that same point, well away from
// the next edge.
module tb_rvfpm_commit_sched;

    logic       ck = 1'b0;
    logic       rst;
    logic [2:0] occupancy;
    logic       err_commit, err_dup_id;
    int         checks = 0;
    int         errors = 0;
`ifdef RVFPM_SCHED_STATS_EN
    logic [31:0] stat_dispatched, stat_killed, stat_stall_cycles;
`endif

    rvfpm_commit_sched_if #(.X_ID_WIDTH(4), .INSTR_WIDTH(32)) xif ();

    rvfpm_commit_sched #(
        .DEPTH       (4),
        .X_ID_WIDTH  (4),
        .INSTR_WIDTH (32)
    ) dut (
        .ck         (ck),
        .rst        (rst),
        .xif        (xif),
        .occupancy  (occupancy),
        .err_commit (err_commit),
        .err_dup_id (err_dup_id)
`ifdef RVFPM_SCHED_STATS_EN
        ,
        .stat_dispatched   (stat_dispatched),
        .stat_killed       (stat_killed),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 ck = ~ck;

    always @(negedge ck) begin
        if (!rst && xif.dispatch_valid && xif.dispatch_ready)
            $display("dispatch id=%0d instr=%08h", xif.dispatch_id, xif.dispatch_instr);
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_issue(input logic v, input logic [3:0] id, input logic [31:0] instr);
        xif.issue_valid  = v;
        xif.issue_accept = v;
        xif.issue_id     = id;
        xif.issue_instr  = instr;
    endtask

    task automatic set_commit(input logic v, input logic [3:0] id, input logic kill);
        xif.commit_valid = v;
        xif.commit_id    = id;
        xif.commit_kill  = kill;
    endtask

    initial begin
        rst = 1'b1;
        set_issue(1'b0, 4'd0, 32'h0);
        set_commit(1'b0, 4'd0, 1'b0);
        xif.dispatch_ready = 1'b0;
        step();
        step();
        chk("rst_issue_ready", 32'(xif.issue_ready), 32'd0);
        chk("rst_dispatch_valid", 32'(xif.dispatch_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_err_commit", 32'(err_commit), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_issue_ready", 32'(xif.issue_ready), 32'd1);

        // Push 3, commit 3, dispatch it.
        set_issue(1'b1, 4'd3, 32'h0000_00A3);
        step();
        set_issue(1'b0, 4'd0, 32'h0);
        chk("t1_occ_after_push", 32'(occupancy), 32'd1);
        chk("t1_dv_pending", 32'(xif.dispatch_valid), 32'd0);
        set_commit(1'b1, 4'd3, 1'b0);
        xif.dispatch_ready = 1'b1;
        step();
        set_commit(1'b0, 4'd0, 1'b0);
        chk("t1_dv", 32'(xif.dispatch_valid), 32'd1);
        chk("t1_did", 32'(xif.dispatch_id), 32'd3);
        chk("t1_dinstr", xif.dispatch_instr, 32'h0000_00A3);
        chk("t1_occ_before_pop", 32'(occupancy), 32'd1);
        step();
        chk("t1_occ_after_pop", 32'(occupancy), 32'd0);
        chk("t1_dv_empty", 32'(xif.dispatch_valid), 32'd0);
        chk("t1_did_empty", 32'(xif.dispatch_id), 32'd0);
        chk("t1_dinstr_empty", xif.dispatch_instr, 32'd0);

        // Valid without accept stores nothing.
        xif.issue_valid  = 1'b1;
        xif.issue_accept = 1'b0;
        xif.issue_id     = 4'd2;
        step();
        set_issue(1'b0, 4'd0, 32'h0);
        chk("noaccept_occ", 32'(occupancy), 32'd0);

        // Fill the buffer with 1..4.
        xif.dispatch_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_issue(1'b1, 4'(i), 32'h100 + 32'(i));
            step();
        end
        set_issue(1'b0, 4'd0, 32'h0);
        chk("t2_full_occ", 32'(occupancy), 32'd4);
        chk("t2_full_ready", 32'(xif.issue_ready), 32'd0);
        set_commit(1'b1, 4'd1, 1'b0);
        xif.dispatch_ready = 1'b1;
        step();
        set_commit(1'b0, 4'd0, 1'b0);
        chk("t2_dv", 32'(xif.dispatch_valid), 32'd1);
        chk("t2_did", 32'(xif.dispatch_id), 32'd1);
        chk("t2_ready_same_cycle", 32'(xif.issue_ready), 32'd0);
        step();
        chk("t2_occ_after_pop", 32'(occupancy), 32'd3);
        chk("t2_ready_after_pop", 32'(xif.issue_ready), 32'd1);
        chk("t2_dv_head_pending", 32'(xif.dispatch_valid), 32'd0);

        // Kill 2,3,4: killed heads drain one per cycle, never dispatched.
        set_commit(1'b1, 4'd2, 1'b1);
        step();
        chk("t2_kill2_dv", 32'(xif.dispatch_valid), 32'd0);
        chk("t2_kill2_occ", 32'(occupancy), 32'd3);
        set_commit(1'b1, 4'd3, 1'b1);
        step();
        chk("t2_kill3_occ", 32'(occupancy), 32'd2);
        set_commit(1'b1, 4'd4, 1'b1);
        step();
        chk("t2_kill4_occ", 32'(occupancy), 32'd1);
        chk("t2_kill4_dv", 32'(xif.dispatch_valid), 32'd0);
        set_commit(1'b0, 4'd0, 1'b0);
        step();
        chk("t2_drained_occ", 32'(occupancy), 32'd0);

        // Push 5,6; commit 6 (blocked by pending 5), kill 5.
        set_issue(1'b1, 4'd5, 32'h55);
        step();
        set_issue(1'b1, 4'd6, 32'h66);
        step();
        set_issue(1'b0, 4'd0, 32'h0);
        set_commit(1'b1, 4'd6, 1'b0);
        step();
        chk("t3_blocked_dv", 32'(xif.dispatch_valid), 32'd0);
        chk("t3_occ", 32'(occupancy), 32'd2);
        set_commit(1'b1, 4'd5, 1'b1);
        step();
        set_commit(1'b0, 4'd0, 1'b0);
        chk("t3_killed_head_dv", 32'(xif.dispatch_valid), 32'd0);
        chk("t3_killed_head_occ", 32'(occupancy), 32'd2);
        step();
        chk("t3_dv6", 32'(xif.dispatch_valid), 32'd1);
        chk("t3_did6", 32'(xif.dispatch_id), 32'd6);
        chk("t3_dinstr6", xif.dispatch_instr, 32'h66);
        chk("t3_occ1", 32'(occupancy), 32'd1);
        step();
        chk("t3_occ0", 32'(occupancy), 32'd0);
        chk("t3_no_err", 32'(err_commit), 32'd0);

        // Commit with nothing in flight.
        set_commit(1'b1, 4'd9, 1'b0);
        step();
        set_commit(1'b0, 4'd0, 1'b0);
        chk("t4_err_commit", 32'(err_commit), 32'd1);
        chk("t4_occ", 32'(occupancy), 32'd0);
        step();
        chk("t4_err_sticky", 32'(err_commit), 32'd1);
        rst = 1'b1;
        step();
        chk("t4_err_cleared", 32'(err_commit), 32'd0);
        chk("t4_rst_ready", 32'(xif.issue_ready), 32'd0);
        rst = 1'b0;

        // Same-edge push and commit of 7, held with dispatch_ready low.
        xif.dispatch_ready = 1'b0;
        set_issue(1'b1, 4'd7, 32'h77);
        set_commit(1'b1, 4'd7, 1'b0);
        step();
        set_issue(1'b0, 4'd0, 32'h0);
        set_commit(1'b0, 4'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("t5_hold_dv", 32'(xif.dispatch_valid), 32'd1);
            chk("t5_hold_did", 32'(xif.dispatch_id), 32'd7);
            chk("t5_hold_dinstr", xif.dispatch_instr, 32'h77);
            if (c < 2) step();
        end
        chk("t5_err_commit", 32'(err_commit), 32'd0);
        xif.dispatch_ready = 1'b1;
        step();
        chk("t5_occ0", 32'(occupancy), 32'd0);

        // Duplicate ids, oldest-first commit, then reset with entries pending.
        xif.dispatch_ready = 1'b0;
        set_issue(1'b1, 4'd8, 32'h81);
        step();
        chk("dup_none_yet", 32'(err_dup_id), 32'd0);
        set_issue(1'b1, 4'd8, 32'h82);
        step();
        chk("dup_flag", 32'(err_dup_id), 32'd1);
        set_issue(1'b1, 4'd10, 32'hA0);
        step();
        set_issue(1'b0, 4'd0, 32'h0);
        chk("t6_occ3", 32'(occupancy), 32'd3);
        set_commit(1'b1, 4'd8, 1'b0);
        step();
        set_commit(1'b0, 4'd0, 1'b0);
        chk("dup_oldest_dv", 32'(xif.dispatch_valid), 32'd1);
        chk("dup_oldest_instr", xif.dispatch_instr, 32'h81);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_rst_occ", 32'(occupancy), 32'd0);
        chk("t6_rst_dv", 32'(xif.dispatch_valid), 32'd0);
        chk("t6_rst_dup", 32'(err_dup_id), 32'd0);
        xif.dispatch_ready = 1'b1;
        set_issue(1'b1, 4'd11, 32'hB1);
        set_commit(1'b1, 4'd11, 1'b0);
        step();
        set_issue(1'b0, 4'd0, 32'h0);
        set_commit(1'b0, 4'd0, 1'b0);
        chk("t6_post_occ", 32'(occupancy), 32'd1);
        chk("t6_post_did", 32'(xif.dispatch_id), 32'd11);
        step();
        chk("t6_post_drain", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
